// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin merge of N_SRC AXI-Stream sources into one registered output stream.
// Define AXIS_ARB_BEAT_COUNT_EN to build the output beat counter; otherwise beat_count is tied to 0.
module axis_rr_arbiter #(
    parameter int N_SRC       = 4,
    parameter int DWIDTH      = 8,
    parameter int TID_WIDTH   = 8,
    parameter int PACKET_MODE = 1
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,
    input  logic [N_SRC*DWIDTH-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]          s_axis_tvalid,
    input  logic [N_SRC-1:0]          s_axis_tlast,
    output logic [N_SRC-1:0]          s_axis_tready,
    input  logic [N_SRC-1:0]          src_enable,
    output logic [DWIDTH-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [TID_WIDTH-1:0]      m_axis_tid,
    input  logic                      m_axis_tready,
    output logic                      busy,
    output logic [31:0]               beat_count
);
    localparam int IW = $clog2(N_SRC);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t                state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d, rr_q, rr_d, pick;
    logic [DWIDTH-1:0]     tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [TID_WIDTH-1:0]  tid_q, tid_d;
    logic [DWIDTH-1:0]     src_data [N_SRC];
    logic [N_SRC-1:0]      req;
    logic                  found, out_ready, accept;

    genvar i;
    generate
        for (i = 0; i < N_SRC; i++) begin : g_slice
            assign src_data[i] = s_axis_tdata[i*DWIDTH +: DWIDTH];
        end
    endgenerate

    assign req           = s_axis_tvalid & src_enable;
    assign out_ready     = !tvalid_q || m_axis_tready;
    assign accept        = (state_q == LOCKED) && s_axis_tvalid[grant_q] && out_ready;
    assign s_axis_tready = (state_q == LOCKED && out_ready) ? N_SRC'(1) << grant_q : '0;

    // First requester strictly after the last grant, wrapping modulo N_SRC.
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!found && req[(int'(rr_q) + k) % N_SRC]) begin
                pick  = IW'((int'(rr_q) + k) % N_SRC);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        if (state_q == IDLE && found) begin
            state_d = LOCKED;
            grant_d = pick;
            rr_d    = pick;
        end
        if (accept) begin
            tvalid_d = 1'b1;
            tdata_d  = src_data[grant_q];
            tlast_d  = s_axis_tlast[grant_q];
            tid_d    = TID_WIDTH'(grant_q);
            if (s_axis_tlast[grant_q] || PACKET_MODE == 0) state_d = IDLE;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= IW'(N_SRC - 1);
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tid_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tid_q    <= tid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = tid_q;
    assign busy          = state_q == LOCKED;

`ifdef AXIS_ARB_BEAT_COUNT_EN
    logic [31:0] count_q;
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) count_q <= '0;
        else if (tvalid_q && m_axis_tready) count_q <= count_q + 32'd1;
    end
    assign beat_count = count_q;
`else
    assign beat_count = '0;
`endif
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed and randomized checks of the arbiter against a transaction-level
// model (per-source beat queues, round-robin pointer, single output slot); a second beat-mode instance.
module tb_axis_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] s_tdata = '0;
    logic [N-1:0]   s_tvalid = '0, s_tlast = '0, en = '1, s_tready;
    logic [W-1:0]   m_tdata;
    logic           m_tvalid, m_tlast, busy, m_tready = 1'b0;
    logic [7:0]     m_tid;
    logic [31:0]    bcnt;

    axis_rr_arbiter #(.N_SRC(N), .DWIDTH(W), .TID_WIDTH(8), .PACKET_MODE(1)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready), .src_enable(en),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid), .m_axis_tready(m_tready), .busy(busy), .beat_count(bcnt)
    );

    logic [15:0] d0_tdata = 16'h2211;
    logic [1:0]  d0_tvalid = '0, d0_tlast = 2'b10, d0_tready;
    logic [7:0]  d0_mdata;
    logic        d0_mvalid, d0_mlast, d0_busy;
    logic [3:0]  d0_tid;
    logic [31:0] d0_bcnt;

    axis_rr_arbiter #(.N_SRC(2), .DWIDTH(8), .TID_WIDTH(4), .PACKET_MODE(0)) dut0 (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s_axis_tdata(d0_tdata), .s_axis_tvalid(d0_tvalid), .s_axis_tlast(d0_tlast),
        .s_axis_tready(d0_tready), .src_enable(2'b11),
        .m_axis_tdata(d0_mdata), .m_axis_tvalid(d0_mvalid), .m_axis_tlast(d0_mlast),
        .m_axis_tid(d0_tid), .m_axis_tready(1'b1), .busy(d0_busy), .beat_count(d0_bcnt)
    );

    int checks = 0, failures = 0, cyc = 0, tb_beats = 0;
    int vpct = 100, rpct = 100, first_v = -1, first_o = -1;
    logic [10:0] pend[$];
    logic [7:0]  out_tids[$];
    logic        locked = 1'b0, ov = 1'b0, ol = 1'b0;
    logic [7:0]  od = '0, oid = '0;
    int          g = 0, rr = N - 1;
    logic [N-1:0] acc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int head_of(input int s);
        foreach (pend[j]) if (int'(pend[j][10:9]) == s) return j;
        return -1;
    endfunction

    function automatic logic [31:0] exp_bcnt();
`ifdef AXIS_ARB_BEAT_COUNT_EN
        return 32'(tb_beats);
`else
        return 32'd0;
`endif
    endfunction

    task automatic push_pkt(input int s, input int len, input logic [7:0] base);
        for (int j = 0; j < len; j++) pend.push_back({2'(s), j == len - 1, 8'(int'(base) + j)});
    endtask

    // One clock: drive sources after negedge, compare against the model, advance the model.
    task automatic step();
        int h;
        logic [N-1:0] req, exp_rdy, hs;
        logic free, take;
        @(negedge clk);
        cyc++;
        m_tready = ($urandom_range(0, 99) < rpct);
        for (int s = 0; s < N; s++) begin
            if (acc[s]) begin
                h = head_of(s);
                if (h >= 0) pend.delete(h);
                s_tvalid[s] = 1'b0;
            end
            if (!s_tvalid[s]) begin
                h = head_of(s);
                if (h >= 0 && $urandom_range(0, 99) < vpct) begin
                    s_tvalid[s] = 1'b1;
                    s_tlast[s] = pend[h][8];
                    s_tdata[s*W +: W] = pend[h][7:0];
                end
            end
        end
        #1;
        if (first_v < 0 && s_tvalid != 0) first_v = cyc;
        if (first_o < 0 && m_tvalid) first_o = cyc;
        req = s_tvalid & en;
        exp_rdy = (locked && (!ov || m_tready)) ? N'(1) << g : '0;
        chk("busy", busy, locked);
        chk("s_tready", s_tready, exp_rdy);
        chk("m_tvalid", m_tvalid, ov);
        if (ov) chk("m_beat", {m_tid, m_tlast, m_tdata}, {oid, ol, od});
        hs = exp_rdy & s_tvalid;
        take = ov && m_tready;
        free = !locked;
        if (take) begin
            tb_beats++;
            out_tids.push_back(oid);
        end
        if (hs != 0) begin
            ov = 1'b1;
            od = s_tdata[g*W +: W];
            ol = s_tlast[g];
            oid = 8'(g);
            if (ol) locked = 1'b0;
        end else if (take) begin
            ov = 1'b0;
        end
        if (free && req != 0) begin
            for (int k = 1; k <= N; k++) if (req[(rr + k) % N]) begin
                g = (rr + k) % N;
                break;
            end
            rr = g;
            locked = 1'b1;
        end
        acc = hs;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pend.size() != 0 || ov || locked) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tid", m_tid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bcnt", bcnt, 0);
        chk("rst_d0_mvalid", d0_mvalid, 0);
        pend.delete();
        out_tids.delete();
        s_tvalid = '0;
        acc = '0;
        locked = 1'b0; ov = 1'b0; ol = 1'b0; od = '0; oid = '0;
        g = 0; rr = N - 1; tb_beats = 0; first_v = -1; first_o = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [47:0] seq;
        int n1, nb;
        do_reset();

        push_pkt(2, 3, 8'hA1);
        drain(50);
        chk("lat_first_out", first_o - first_v, 2);
        chk("n_beats_src2", out_tids.size(), 3);
        chk("bcnt_src2", bcnt, exp_bcnt());

        do_reset();
        push_pkt(0, 2, 8'h10);
        push_pkt(1, 2, 8'h20);
        push_pkt(3, 2, 8'h30);
        drain(100);
        seq = '0;
        foreach (out_tids[j]) seq = {seq[39:0], out_tids[j]};
        chk("rr_order", seq, 48'h0000_0101_0303);

        out_tids.delete();
        push_pkt(1, 6, 8'h40);
        repeat (4) step();
        rpct = 0;
        repeat (5) step();
        rpct = 100;
        drain(50);
        chk("n_beats_stall", out_tids.size(), 6);

        do_reset();
        en = 4'b1101;
        rpct = 80;
        push_pkt(1, 2, 8'h50);
        push_pkt(0, 2, 8'h60);
        push_pkt(0, 2, 8'h70);
        repeat (20) step();
        n1 = 0;
        foreach (out_tids[j]) if (out_tids[j] == 8'd1) n1++;
        chk("disabled_src_granted", n1, 0);
        chk("enabled_src_beats", out_tids.size(), 4);
        en = '1;
        drain(50);
        chk("late_src1_tid", out_tids[out_tids.size() - 1], 1);
        push_pkt(2, 8, 8'h80);
        repeat (4) step();
        do_reset();
        repeat (3) step();

        d0_tvalid = 2'b11;
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (d0_mvalid) begin
                chk("beat_mode_tid", d0_tid, nb % 2);
                chk("beat_mode_tlast", d0_mlast, nb % 2);
                chk("beat_mode_data", d0_mdata, (nb % 2) ? 8'h22 : 8'h11);
                nb++;
            end
        end
        chk("beat_mode_n", nb, 5);
        d0_tvalid = '0;

        do_reset();
        rpct = 100;
        push_pkt(3, 4, 8'h90);
        push_pkt(0, 6, 8'hB0);
        drain(100);
`ifdef AXIS_ARB_BEAT_COUNT_EN
        chk("bcnt_ten", bcnt, 10);
`else
        chk("bcnt_ten", bcnt, 0);
`endif

        do_reset();
        vpct = 60;
        rpct = 70;
        for (int r = 0; r < 10; r++) begin
            en = 4'($urandom_range(1, 15));
            for (int s = 0; s < N; s++)
                if ($urandom_range(0, 1) == 1) push_pkt(s, int'($urandom_range(1, 4)), 8'($urandom));
            repeat (15) step();
        end
        en = '1;
        drain(2000);
        chk("bcnt_random", bcnt, exp_bcnt());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of AXIS source ports, 2..8.
REQ-002 Parameter DWIDTH, default 8: tdata width per source and on output.
REQ-003 Parameter TID_WIDTH, default 8: output tid width, SHALL be >= clog2(N_SRC).
REQ-004 Parameter PACKET_MODE, default 1: 1 = grant held until tlast beat; 0 = grant released after every beat.
REQ-005 axis_aclk  in  1  single clock for all logic.
REQ-006 axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-007 s_axis_tdata  in  N_SRC*DWIDTH  source data, source i at slice i.
REQ-008 s_axis_tvalid  in  N_SRC  source valid.
REQ-009 s_axis_tlast  in  N_SRC  source end-of-packet.
REQ-010 s_axis_tready  out  N_SRC  source ready.
REQ-011 src_enable  in  N_SRC  per-source arbitration enable, static or quasi-static.
REQ-012 m_axis_tdata  out  DWIDTH  merged data, toward FIFO write side.
REQ-013 m_axis_tvalid / m_axis_tlast  out  1 each  merged valid / end-of-packet.
REQ-014 m_axis_tid  out  TID_WIDTH  index of originating source, zero-extended.
REQ-015 m_axis_tready  in  1  downstream ready (FIFO not full).
REQ-016 busy  out  1  high while a grant is held.
REQ-017 beat_count  out  32  total beats accepted on output (see Configuration).

Function
REQ-018 FSM states IDLE and LOCKED; register grant_idx and rr_ptr (last granted index).
REQ-019 IDLE: request set = s_axis_tvalid & src_enable; if non-empty, grant first requester searching from rr_ptr+1 upward with wrap modulo N_SRC, go LOCKED next edge, rr_ptr <= grant.
REQ-020 IDLE with empty request set: stay IDLE, all s_axis_tready low.
REQ-021 LOCKED: s_axis_tready[grant_idx] = !m_axis_tvalid || m_axis_tready; all other tready bits SHALL be 0.
REQ-022 Accepted beat (tvalid&tready on granted source) SHALL load output register: tdata, tlast, tid=grant_idx, m_axis_tvalid=1; output latency exactly 1 cycle.
REQ-023 Output register SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0; clears valid when consumed with no new beat.
REQ-024 PACKET_MODE=1: LOCKED -> IDLE on acceptance of a beat with tlast=1; otherwise stay LOCKED regardless of source tvalid gaps.
REQ-025 PACKET_MODE=0: LOCKED -> IDLE after every accepted beat; m_axis_tlast still forwards source tlast.
REQ-026 Deasserting src_enable of the granted source mid-packet SHALL NOT break the grant; it affects only subsequent arbitration.
REQ-027 Simultaneous requests: round-robin order per REQ-019; no source starves while it holds tvalid.
REQ-028 busy = (state == LOCKED).

Reset
REQ-029 On axis_aresetn low, asynchronously: state=IDLE, grant_idx=0, rr_ptr=N_SRC-1 (source 0 wins first), m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, beat_count=0, all s_axis_tready=0.
REQ-030 Reset mid-packet SHALL discard the partial packet and output beat; no state survives.

Configuration
REQ-031 Macro AXIS_ARB_BEAT_COUNT_EN defined: beat_count increments by 1 on each m_axis_tvalid&m_axis_tready, wraps 0xFFFFFFFF->0.
REQ-032 Macro undefined: beat_count tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-033 Reset release, source 2 sends 3-beat packet 0xA1,0xA2,0xA3(tlast), tready=1 -> output same 3 beats, tid=2, tlast only on 0xA3, first output 2 cycles after tvalid.
REQ-034 Sources 0,1,3 all valid with 2-beat packets, PACKET_MODE=1 -> output order 0,0,1,1,3,3, never interleaved, tid matches.
REQ-035 Output tready held low 5 cycles mid-packet -> m_axis_tdata/tid/tlast stable, no beat lost or duplicated, source tready low for those cycles.
REQ-036 PACKET_MODE=0, sources 0 and 1 continuously valid -> tids alternate 0,1,0,1.
REQ-037 src_enable[1]=0 with source 1 valid -> source 1 never granted, s_axis_tready[1]=0; reset asserted mid-packet -> all outputs 0 next sample.
REQ-038 With AXIS_ARB_BEAT_COUNT_EN, 10 beats transferred -> beat_count=10; without macro -> beat_count=0.
